// File: rtl/vae_recon_loss_if.sv
// Bundle between the VAE forward datapath and the reconstruction-loss stage.
// Carries the start/busy/done handshake, the 18 operands and the results.
interface vae_recon_loss_if;
    logic        start;
    logic [15:0] out1, out2, out3, out4, out5, out6, out7, out8, out9;
    logic [15:0] x1, x2, x3, x4, x5, x6, x7, x8, x9;
    logic        busy;
    logic        done;
    logic [15:0] loss;
    logic [15:0] err1, err2, err3, err4, err5, err6, err7, err8, err9;

    modport master (
        output start,
        output out1, out2, out3, out4, out5, out6, out7, out8, out9,
        output x1, x2, x3, x4, x5, x6, x7, x8, x9,
        input  busy, done, loss,
        input  err1, err2, err3, err4, err5, err6, err7, err8, err9
    );

    modport slave (
        input  start,
        input  out1, out2, out3, out4, out5, out6, out7, out8, out9,
        input  x1, x2, x3, x4, x5, x6, x7, x8, x9,
        output busy, done, loss,
        output err1, err2, err3, err4, err5, err6, err7, err8, err9
    );
endinterface

// File: rtl/vae_recon_loss.sv
// Reconstruction-loss stage: latches out/x vectors, then walks nine
// elements through one shared squarer to build error vector and SSE loss.
module vae_recon_loss #(
    parameter int N_ELEM = 9,
    parameter int ACC_W  = 28
) (
    input  logic              clk,
    input  logic              rst,
    vae_recon_loss_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [3:0]         idx_q, idx_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [15:0]        loss_q, loss_d;
    logic [15:0]        out_q [N_ELEM];
    logic [15:0]        out_d [N_ELEM];
    logic [15:0]        x_q   [N_ELEM];
    logic [15:0]        x_d   [N_ELEM];
    logic [15:0]        err_q [N_ELEM];
    logic [15:0]        err_d [N_ELEM];

    logic signed [15:0] a_sel, b_sel;
    logic signed [16:0] diff;
    logic signed [15:0] e;
    logic signed [31:0] prod;
    logic [31:0]        sq;
    logic [31:0]        acc_sum;
    logic [15:0]        loss_sat;
    logic               last;
    logic               busy_c, done_c;

    // State and datapath registers, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
            loss_q  <= '0;
            for (int i = 0; i < N_ELEM; i++) begin
                out_q[i] <= '0;
                x_q[i]   <= '0;
                err_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            loss_q  <= loss_d;
            for (int i = 0; i < N_ELEM; i++) begin
                out_q[i] <= out_d[i];
                x_q[i]   <= x_d[i];
                err_q[i] <= err_d[i];
            end
        end
    end

    // Shared error/square/accumulate path for the current element
    always_comb begin
        a_sel = out_q[idx_q];
        b_sel = x_q[idx_q];
        diff  = 17'(a_sel) - 17'(b_sel);
        if (diff[16] != diff[15]) begin
            e = diff[16] ? 16'sh8000 : 16'sh7FFF;
        end else begin
            e = diff[15:0];
        end
        prod    = 32'(e) * 32'(e);
        sq      = $unsigned(prod) >> 8;
        acc_sum = 32'(acc_q) + sq;
        if (acc_sum > 32'h0000_7FFF) begin
            loss_sat = 16'h7FFF;
        end else begin
            loss_sat = acc_sum[15:0];
        end
        last = (idx_q == 4'(N_ELEM - 1));
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values for operand latches, index, accumulator and results
    always_comb begin
        idx_d  = idx_q;
        acc_d  = acc_q;
        loss_d = loss_q;
        out_d  = out_q;
        x_d    = x_q;
        err_d  = err_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    idx_d    = '0;
                    acc_d    = '0;
                    out_d[0] = bus.out1;
                    out_d[1] = bus.out2;
                    out_d[2] = bus.out3;
                    out_d[3] = bus.out4;
                    out_d[4] = bus.out5;
                    out_d[5] = bus.out6;
                    out_d[6] = bus.out7;
                    out_d[7] = bus.out8;
                    out_d[8] = bus.out9;
                    x_d[0]   = bus.x1;
                    x_d[1]   = bus.x2;
                    x_d[2]   = bus.x3;
                    x_d[3]   = bus.x4;
                    x_d[4]   = bus.x5;
                    x_d[5]   = bus.x6;
                    x_d[6]   = bus.x7;
                    x_d[7]   = bus.x8;
                    x_d[8]   = bus.x9;
                end
            end
            RUN: begin
                err_d[idx_q] = e;
                acc_d        = acc_sum[ACC_W-1:0];
                if (last) begin
                    loss_d = loss_sat;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            default: ;
        endcase
    end

    // Handshake outputs decoded from the state register
    always_comb begin
        busy_c = 1'b0;
        done_c = 1'b0;
        unique case (state_q)
            IDLE:    ;
            RUN:     busy_c = 1'b1;
            DONE: begin
                busy_c = 1'b1;
                done_c = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.busy = busy_c;
    assign bus.done = done_c;
    assign bus.loss = loss_q;
    assign bus.err1 = err_q[0];
    assign bus.err2 = err_q[1];
    assign bus.err3 = err_q[2];
    assign bus.err4 = err_q[3];
    assign bus.err5 = err_q[4];
    assign bus.err6 = err_q[5];
    assign bus.err7 = err_q[6];
    assign bus.err8 = err_q[7];
    assign bus.err9 = err_q[8];

endmodule

// File: tb/tb_vae_recon_loss.sv
// Self-checking bench for vae_recon_loss: table vectors, random runs
// against an arithmetic model, and multi-cycle handshake corner cases.
module tb_vae_recon_loss;

    typedef logic [8:0][15:0] vec9_t;

    typedef struct {
        string       name;
        vec9_t       o;
        vec9_t       x;
        vec9_t       err;
        logic [15:0] loss;
    } tv_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    vae_recon_loss_if bus ();

    vae_recon_loss dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", n, act, exp);
        end
    endtask

    task automatic drive(input vec9_t o, input vec9_t x);
        bus.out1 = o[0]; bus.out2 = o[1]; bus.out3 = o[2];
        bus.out4 = o[3]; bus.out5 = o[4]; bus.out6 = o[5];
        bus.out7 = o[6]; bus.out8 = o[7]; bus.out9 = o[8];
        bus.x1 = x[0]; bus.x2 = x[1]; bus.x3 = x[2];
        bus.x4 = x[3]; bus.x5 = x[4]; bus.x6 = x[5];
        bus.x7 = x[6]; bus.x8 = x[7]; bus.x9 = x[8];
    endtask

    function automatic vec9_t get_err();
        vec9_t r;
        r[0] = bus.err1; r[1] = bus.err2; r[2] = bus.err3;
        r[3] = bus.err4; r[4] = bus.err5; r[5] = bus.err6;
        r[6] = bus.err7; r[7] = bus.err8; r[8] = bus.err9;
        return r;
    endfunction

    // Reference: saturated differences, floor(e^2/256) summed, clamped
    function automatic void model(input vec9_t o, input vec9_t x,
                                  output vec9_t err,
                                  output logic [15:0] loss);
        longint sum = 0;
        for (int k = 0; k < 9; k++) begin
            int d;
            d = int'($signed(o[k])) - int'($signed(x[k]));
            if (d > 32767) d = 32767;
            if (d < -32768) d = -32768;
            err[k] = 16'(d);
            sum += longint'((d * d) / 256);
        end
        loss = (sum > 32767) ? 16'h7FFF : 16'(sum);
    endfunction

    function automatic tv_t uni(input string n, input logic [15:0] ov,
                                input logic [15:0] xv,
                                input logic [15:0] ev,
                                input logic [15:0] lv);
        tv_t t;
        t.name = n;
        for (int k = 0; k < 9; k++) begin
            t.o[k]   = ov;
            t.x[k]   = xv;
            t.err[k] = ev;
        end
        t.loss = lv;
        return t;
    endfunction

    // One full run from start, checking cycle-exact busy/done and results
    task automatic run_vec(input string n, input vec9_t o, input vec9_t x,
                           input vec9_t err_e, input logic [15:0] loss_e);
        int    busy_cnt = 0;
        int    done_cnt = 0;
        vec9_t got;
        drive(o, x);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int i = 0; i <= 10; i++) begin
            if (bus.busy) busy_cnt++;
            if (bus.done) done_cnt++;
            if (i == 9) begin
                chk({n, " done@N+9"}, 32'(bus.done), 32'd1);
                got = get_err();
                for (int k = 0; k < 9; k++)
                    chk($sformatf("%s err%0d", n, k + 1),
                        32'(got[k]), 32'(err_e[k]));
                chk({n, " loss"}, 32'(bus.loss), 32'(loss_e));
            end
            if (i < 10) begin
                @(posedge clk);
                #1;
            end
        end
        chk({n, " busy_cycles"}, 32'(busy_cnt), 32'd10);
        chk({n, " done_pulses"}, 32'(done_cnt), 32'd1);
    endtask

    tv_t   tbl[6];
    vec9_t ro, rx, re, got;
    logic [15:0] rl;

    initial begin
        bus.start = 1'b0;
        drive('0, '0);

        tbl[0] = uni("identity", 16'h1234, 16'h1234, 16'h0000, 16'h0000);
        tbl[1] = uni("single1", 16'h0555, 16'h0555, 16'h0000, 16'h0100);
        tbl[1].o[0] = 16'h0100;
        tbl[1].x[0] = 16'h0000;
        tbl[1].err[0] = 16'h0100;
        tbl[2] = uni("single5", 16'h0A0A, 16'h0A0A, 16'h0000, 16'h0400);
        tbl[2].o[4] = 16'h0000;
        tbl[2].x[4] = 16'h0200;
        tbl[2].err[4] = 16'hFE00;
        tbl[3] = uni("accum", 16'h0080, 16'h0000, 16'h0080, 16'h0240);
        tbl[4] = uni("sat_pos", 16'h7FFF, 16'h8000, 16'h7FFF, 16'h7FFF);
        tbl[5] = uni("sat_neg", 16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF);

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset done", 32'(bus.done), 32'd0);
        chk("reset loss", 32'(bus.loss), 32'd0);
        got = get_err();
        chk("reset err", 32'(|got), 32'd0);

        for (int t = 0; t < 6; t++)
            run_vec(tbl[t].name, tbl[t].o, tbl[t].x, tbl[t].err,
                    tbl[t].loss);

        for (int r = 0; r < 20; r++) begin
            for (int k = 0; k < 9; k++) begin
                if (r < 10) begin
                    ro[k] = 16'($urandom_range(0, 1023)) - 16'd512;
                    rx[k] = 16'($urandom_range(0, 1023)) - 16'd512;
                end else begin
                    ro[k] = 16'($urandom);
                    rx[k] = 16'($urandom);
                end
            end
            model(ro, rx, re, rl);
            run_vec($sformatf("rand%0d", r), ro, rx, re, rl);
        end

        // Inputs change and start re-pulses mid-run: no effect
        ro = tbl[3].o;
        rx = tbl[3].x;
        drive(ro, rx);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        begin
            int dcnt = 0;
            for (int i = 1; i <= 25; i++) begin
                @(posedge clk);
                #1;
                if (i == 3) begin
                    drive(tbl[4].o, tbl[4].x);
                    bus.start = 1'b1;
                end
                if (i == 5) bus.start = 1'b0;
                if (bus.done) dcnt++;
                if (i == 9) begin
                    chk("latch loss", 32'(bus.loss), 32'h0240);
                    got = get_err();
                    chk("latch err9", 32'(got[8]), 32'h0080);
                end
            end
            chk("latch done_once", 32'(dcnt), 32'd1);
        end

        // Start held high: re-trigger on first IDLE cycle (N+11)
        drive(tbl[1].o, tbl[1].x);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        repeat (10) @(posedge clk);
        #1;
        chk("b2b idle@N+10", 32'(bus.busy), 32'd0);
        @(posedge clk);
        #1;
        chk("b2b busy@N+11", 32'(bus.busy), 32'd1);
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("b2b done2", 32'(bus.done), 32'd1);
        chk("b2b loss2", 32'(bus.loss), 32'h0100);
        @(posedge clk);
        #1;

        // Reset mid-run after a saturating run left loss nonzero
        run_vec("pre_rst", tbl[4].o, tbl[4].x, tbl[4].err, tbl[4].loss);
        drive(tbl[2].o, tbl[2].x);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid_rst busy", 32'(bus.busy), 32'd0);
        chk("mid_rst loss", 32'(bus.loss), 32'd0);
        got = get_err();
        chk("mid_rst err", 32'(|got), 32'd0);
        begin
            int dcnt = 0;
            for (int i = 0; i < 12; i++) begin
                if (bus.done) dcnt++;
                @(posedge clk);
                #1;
            end
            chk("mid_rst no_done", 32'(dcnt), 32'd0);
        end
        run_vec("post_rst", tbl[2].o, tbl[2].x, tbl[2].err, tbl[2].loss);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
